// File: rtl/systolic_matrix_streamer_if.sv
// Stream and array-side bundle for systolic_matrix_streamer.
// Groups the A/B operand streams, the result stream and the array-facing
// operand/result buses.
//   slave  : the streamer (consumes A/B, drives flats/start, drives result stream)
//   master : the host fabric plus array model on the other side
interface systolic_matrix_streamer_if #(
  parameter int ARRAY_SIZE   = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int WEIGHT_WIDTH = 8
);
  localparam int NELEM = ARRAY_SIZE * ARRAY_SIZE;

  // Operand stream A (row-major, S5.10)
  logic                          s_a_valid;
  logic                          s_a_ready;
  logic [DATA_WIDTH-1:0]         s_a_data;
  // Operand stream B (row-major, S1.6)
  logic                          s_b_valid;
  logic                          s_b_ready;
  logic [WEIGHT_WIDTH-1:0]       s_b_data;
  // Array-facing operand buses and control
  logic [DATA_WIDTH*NELEM-1:0]   matrix_a_flat;
  logic [WEIGHT_WIDTH*NELEM-1:0] matrix_b_flat;
  logic                          start;
  logic                          done;
  logic                          result_valid;
  logic [DATA_WIDTH*NELEM-1:0]   result_flat;
  // Result stream (row-major)
  logic                          m_valid;
  logic                          m_ready;
  logic [DATA_WIDTH-1:0]         m_data;
  logic                          m_last;

  modport slave (
    input  s_a_valid, s_a_data, s_b_valid, s_b_data,
    output s_a_ready, s_b_ready,
    output matrix_a_flat, matrix_b_flat, start,
    input  done, result_valid, result_flat,
    output m_valid, m_data, m_last,
    input  m_ready
  );

  modport master (
    output s_a_valid, s_a_data, s_b_valid, s_b_data,
    input  s_a_ready, s_b_ready,
    input  matrix_a_flat, matrix_b_flat, start,
    output done, result_valid, result_flat,
    input  m_valid, m_data, m_last,
    output m_ready
  );
endinterface

// File: rtl/systolic_matrix_streamer.sv
// Host-side sequencer for a systolic array.
// Collects N*N A elements and N*N B elements from two independent streams,
// packs them into the array operand buses, pulses start, waits (with a
// watchdog) for done, captures the result matrix and streams it out
// row-major with valid/ready.
// Ports:
//   clk, rst     : single clock, synchronous active-high reset
//   bus (slave)  : A/B input streams, array operand/result buses, result stream
//   busy         : high whenever the sequencer is not in LOAD
//   timeout_err  : sticky watchdog flag, cleared only by rst
module systolic_matrix_streamer #(
  parameter int ARRAY_SIZE     = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  systolic_matrix_streamer_if.slave        bus,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int NELEM = ARRAY_SIZE * ARRAY_SIZE;
  // Operand counters must be able to hold NELEM itself ("full").
  localparam int CNT_W = $clog2(NELEM + 1);
  // Result index only ever spans 0..NELEM-1.
  localparam int IDX_W = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0] NELEM_C  = CNT_W'(NELEM);
  localparam logic [CNT_W-1:0] NELEM_M1 = CNT_W'(NELEM - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                  state_r;
  logic [CNT_W-1:0]        a_cnt_r;
  logic [CNT_W-1:0]        b_cnt_r;
  logic [IDX_W-1:0]        r_cnt_r;
  logic [WD_W-1:0]         wd_r;
  logic                    timeout_err_r;
  logic [DATA_WIDTH-1:0]   a_mem_r   [NELEM];
  logic [WEIGHT_WIDTH-1:0] b_mem_r   [NELEM];
  logic [DATA_WIDTH-1:0]   res_mem_r [NELEM];

  logic a_hs_s;
  logic b_hs_s;
  logic a_full_next_s;
  logic b_full_next_s;

  // Ready/valid decode is purely from registered state so there is no
  // combinational path from s_*_valid or m_ready to any output.
  assign bus.s_a_ready = (state_r == ST_LOAD) && (a_cnt_r < NELEM_C);
  assign bus.s_b_ready = (state_r == ST_LOAD) && (b_cnt_r < NELEM_C);
  assign bus.start     = (state_r == ST_START);
  assign bus.m_valid   = (state_r == ST_DRAIN);
  assign bus.m_last    = (state_r == ST_DRAIN) && (r_cnt_r == LAST_IDX);
  assign bus.m_data    = res_mem_r[r_cnt_r];
  assign busy          = (state_r != ST_LOAD);
  assign timeout_err   = timeout_err_r;

  assign a_hs_s = bus.s_a_valid & bus.s_a_ready;
  assign b_hs_s = bus.s_b_valid & bus.s_b_ready;

  // Look ahead one handshake so START follows the last operand immediately.
  assign a_full_next_s = (a_cnt_r == NELEM_C) || ((a_cnt_r == NELEM_M1) && a_hs_s);
  assign b_full_next_s = (b_cnt_r == NELEM_C) || ((b_cnt_r == NELEM_M1) && b_hs_s);

  // Element k of each operand memory occupies slice k of its flat bus.
  for (genvar gk = 0; gk < NELEM; gk++) begin : g_flat
    assign bus.matrix_a_flat[gk*DATA_WIDTH +: DATA_WIDTH]     = a_mem_r[gk];
    assign bus.matrix_b_flat[gk*WEIGHT_WIDTH +: WEIGHT_WIDTH] = b_mem_r[gk];
  end

  // Sequencer FSM with operand fill, watchdog, result capture and drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_LOAD;
      a_cnt_r       <= '0;
      b_cnt_r       <= '0;
      r_cnt_r       <= '0;
      wd_r          <= '0;
      timeout_err_r <= 1'b0;
      for (int k = 0; k < NELEM; k++) begin
        a_mem_r[k]   <= '0;
        b_mem_r[k]   <= '0;
        res_mem_r[k] <= '0;
      end
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (a_hs_s) begin
            for (int k = 0; k < NELEM; k++) begin
              if (a_cnt_r == CNT_W'(k)) begin
                a_mem_r[k] <= bus.s_a_data;
              end
            end
            a_cnt_r <= a_cnt_r + CNT_W'(1);
          end
          if (b_hs_s) begin
            for (int k = 0; k < NELEM; k++) begin
              if (b_cnt_r == CNT_W'(k)) begin
                b_mem_r[k] <= bus.s_b_data;
              end
            end
            b_cnt_r <= b_cnt_r + CNT_W'(1);
          end
          if (a_full_next_s && b_full_next_s) begin
            state_r <= ST_START;
          end
        end
        ST_START: begin
          // done is deliberately ignored here; the array cannot have finished yet.
          wd_r    <= '0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          // done takes priority over a watchdog expiry in the same cycle.
          if (bus.done) begin
            for (int k = 0; k < NELEM; k++) begin
              res_mem_r[k] <= bus.result_flat[k*DATA_WIDTH +: DATA_WIDTH];
            end
            r_cnt_r <= '0;
            state_r <= ST_DRAIN;
          end else if (wd_r == WD_LAST) begin
            timeout_err_r <= 1'b1;
            a_cnt_r       <= '0;
            b_cnt_r       <= '0;
            r_cnt_r       <= '0;
            state_r       <= ST_LOAD;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        ST_DRAIN: begin
          // m_valid is constantly high in DRAIN, so m_ready alone marks a handshake.
          if (bus.m_ready) begin
            if (r_cnt_r == LAST_IDX) begin
              a_cnt_r <= '0;
              b_cnt_r <= '0;
              r_cnt_r <= '0;
              state_r <= ST_LOAD;
            end else begin
              r_cnt_r <= r_cnt_r + IDX_W'(1);
            end
          end
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_matrix_streamer.sv
// Self-checking bench for systolic_matrix_streamer (N=2, TIMEOUT_CYCLES=16).
// A behavioural array stand-in answers start with done/result_flat; every
// result it hands over is pushed to a scoreboard queue and popped when the
// streamer's result stream handshakes.
module tb_systolic_matrix_streamer;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int TO = 16;

  logic clk;
  logic rst;
  logic busy;
  logic timeout_err;

  systolic_matrix_streamer_if #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) bus ();

  systolic_matrix_streamer #(
    .ARRAY_SIZE(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int hs_cnt    = 0;
  int start_cnt = 0;
  logic [16:0] exp_q [$];

  logic       hold_ready = 1'b1;
  logic       bp_en      = 1'b0;
  int         bp_i       = 0;
  logic [3:0] bp_pat     = 4'b1001;  // m_ready sequence 1,0,0,1 from bit 0

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference array: C = A*B, S5.10 x S1.6 products scaled back to S5.10.
  function automatic logic [63:0] mat_mul(input logic [63:0] a, input logic [31:0] b);
    logic [63:0]        r;
    logic signed [15:0] ae;
    logic signed [7:0]  be;
    int                 acc;
    int                 sh;
    r = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc = 0;
        for (int k = 0; k < N; k++) begin
          ae  = a[(i*N+k)*DW +: DW];
          be  = b[(k*N+j)*WW +: WW];
          acc = acc + ae * be;
        end
        sh = acc >>> 6;
        r[(i*N+j)*DW +: DW] = sh[15:0];
      end
    end
    return r;
  endfunction

  // m_ready driver: fixed hold value or the backpressure pattern.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bp_en) begin
        bus.m_ready = bp_pat[bp_i];
        bp_i = (bp_i + 1) % 4;
      end else begin
        bus.m_ready = hold_ready;
      end
    end
  end

  // Result-stream monitor: scoreboard pops, stability under stall, start count.
  initial begin
    logic        stall;
    logic [15:0] held_d;
    logic        held_l;
    logic [16:0] e;
    stall = 1'b0;
    held_d = '0;
    held_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (bus.start) start_cnt++;
        if (stall) begin
          chk_val("hold_valid", bus.m_valid, 1'b1);
          chk_val("hold_data", bus.m_data, held_d);
          chk_val("hold_last", bus.m_last, held_l);
        end
        if (bus.m_valid) begin
          if (exp_q.size() == 0) begin
            chk_val("spurious_m_valid", bus.m_valid, 1'b0);
          end else if (bus.m_ready) begin
            e = exp_q.pop_front();
            chk_val("m_data", bus.m_data, e[15:0]);
            chk_val("m_last", bus.m_last, e[16]);
            hs_cnt++;
          end
        end
        stall  = bus.m_valid & ~bus.m_ready;
        held_d = bus.m_data;
        held_l = bus.m_last;
      end
    end
  end

  task automatic send_a(input logic [15:0] d, input int gap);
    logic r;
    int   n;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_a_valid = 1'b1;
    bus.s_a_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      r = bus.s_a_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 50) begin
        chk_val("a_ready_timeout", bus.s_a_ready, 1'b1);
        break;
      end
    end
    bus.s_a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input int gap);
    logic r;
    int   n;
    repeat (gap) begin @(posedge clk); #1; end
    bus.s_b_valid = 1'b1;
    bus.s_b_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      r = bus.s_b_ready;
      @(posedge clk);
      #1;
      if (r) break;
      n++;
      if (n > 50) begin
        chk_val("b_ready_timeout", bus.s_b_ready, 1'b1);
        break;
      end
    end
    bus.s_b_valid = 1'b0;
  endtask

  // mode 0: A and B concurrently; mode 1: all of B, then A with gaps.
  task automatic feed(input logic [63:0] a, input logic [31:0] b, input int mode);
    if (mode == 0) begin
      fork
        begin for (int k = 0; k < 4; k++) send_a(a[k*DW +: DW], k % 2); end
        begin for (int k = 0; k < 4; k++) send_b(b[k*WW +: WW], 0); end
      join
    end else begin
      for (int k = 0; k < 4; k++) send_b(b[k*WW +: WW], 0);
      for (int k = 0; k < 4; k++) send_a(a[k*DW +: DW], 1 + (k % 2));
    end
  endtask

  // Whole job: feed, check start, answer (or not) with done, drain.
  task automatic run_job(input logic [63:0] a, input logic [31:0] b, input logic [63:0] res,
                         input int mode, input int lat, input bit spur, input bit bp);
    int sc0;
    int hs0;
    int n;
    sc0 = start_cnt;
    hs0 = hs_cnt;
    feed(a, b, mode);
    if (spur) begin
      bus.done        = 1'b1;
      bus.result_flat = ~res;
    end
    @(negedge clk);
    chk_val("start_after_last", bus.start, 1'b1);
    chk_val("flat_a_at_start", bus.matrix_a_flat, a);
    chk_val("flat_b_at_start", bus.matrix_b_flat, b);
    @(posedge clk);
    #1;
    bus.done = 1'b0;
    @(negedge clk);
    chk_val("start_one_cycle", bus.start, 1'b0);
    chk_val("wait_busy", busy, 1'b1);
    chk_val("wait_no_valid", bus.m_valid, 1'b0);
    if (lat < 0) begin
      n = 1;
      while (n < 100) begin
        @(negedge clk);
        if (timeout_err) break;
        n++;
      end
      chk_val("timeout_latency", n, TO);
      chk_val("timeout_a_ready", bus.s_a_ready, 1'b1);
      chk_val("timeout_idle", busy, 1'b0);
      @(negedge clk);
      chk_val("timeout_a_ready_next", bus.s_a_ready, 1'b1);
      chk_val("timeout_sticky", timeout_err, 1'b1);
      repeat (3) @(negedge clk);
      chk_val("timeout_no_drain", hs_cnt - hs0, 0);
    end else begin
      @(posedge clk);
      #1;
      repeat (lat) begin @(posedge clk); #1; end
      for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), res[k*DW +: DW]});
      bus.done        = 1'b1;
      bus.result_flat = res;
      @(posedge clk);
      #1;
      bus.done        = 1'b0;
      bus.result_flat = ~res;
      if (bp) begin
        bp_i  = 0;
        bp_en = 1'b1;
      end
      @(negedge clk);
      chk_val("valid_after_done", bus.m_valid, 1'b1);
      chk_val("flat_a_in_drain", bus.matrix_a_flat, a);
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk_val("drain_complete", exp_q.size(), 0);
      bp_en = 1'b0;
      @(negedge clk);
      chk_val("reload_a_ready", bus.s_a_ready, 1'b1);
      chk_val("reload_b_ready", bus.s_b_ready, 1'b1);
      chk_val("reload_idle", busy, 1'b0);
      chk_val("drain_handshakes", hs_cnt - hs0, 4);
    end
    chk_val("start_pulses", start_cnt - sc0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk_val({tag, "_a_ready"}, bus.s_a_ready, 1'b1);
    chk_val({tag, "_b_ready"}, bus.s_b_ready, 1'b1);
    chk_val({tag, "_busy"}, busy, 1'b0);
    chk_val({tag, "_start"}, bus.start, 1'b0);
    chk_val({tag, "_m_valid"}, bus.m_valid, 1'b0);
    chk_val({tag, "_m_last"}, bus.m_last, 1'b0);
    chk_val({tag, "_m_data"}, bus.m_data, 16'h0000);
    chk_val({tag, "_flat_a"}, bus.matrix_a_flat, 64'h0);
    chk_val({tag, "_flat_b"}, bus.matrix_b_flat, 32'h0);
    chk_val({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [63:0] id_a;
    logic [31:0] id_b;
    logic [63:0] gen_a;
    logic [31:0] gen_b;
    logic [63:0] bp_res;
    int          hs0;

    id_a   = 64'h0400_0000_0000_0400;
    id_b   = 32'h4000_0040;
    gen_a  = {16'h0400, 16'hFC00, 16'h0200, 16'h0800};
    gen_b  = {8'h40, 8'hE0, 8'h20, 8'h40};
    bp_res = {16'h0400, 16'hFC00, 16'h0800, 16'h0C00};

    rst = 1'b1;
    bus.s_a_valid    = 1'b0;
    bus.s_a_data     = '0;
    bus.s_b_valid    = 1'b0;
    bus.s_b_data     = '0;
    bus.done         = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_flat  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("reset");

    // Spurious done while loading must not move the FSM or capture anything.
    @(posedge clk);
    #1;
    bus.done        = 1'b1;
    bus.result_flat = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    #1;
    bus.done = 1'b0;
    @(negedge clk);
    chk_val("load_done_busy", busy, 1'b0);
    chk_val("load_done_ready", bus.s_a_ready, 1'b1);
    chk_val("load_done_no_valid", bus.m_valid, 1'b0);
    @(posedge clk);
    #1;

    // Identity with a spurious done in the START cycle.
    chk_val("identity_model", mat_mul(id_a, id_b), id_a);
    run_job(id_a, id_b, mat_mul(id_a, id_b), 0, 2, 1'b1, 1'b0);
    // Order independence: B first, A with gaps.
    run_job(id_a, id_b, mat_mul(id_a, id_b), 1, 1, 1'b0, 1'b0);
    // General matrices, concurrent streams.
    run_job(gen_a, gen_b, mat_mul(gen_a, gen_b), 0, 4, 1'b0, 1'b0);
    // Backpressure on the result stream.
    run_job(gen_a, id_b, bp_res, 0, 1, 1'b0, 1'b1);
    // Watchdog expiry, then a normal job with the flag still set.
    run_job(id_a, gen_b, 64'h0, 1, -1, 1'b0, 1'b0);
    run_job(gen_a, gen_b, mat_mul(gen_a, gen_b), 0, 0, 1'b0, 1'b0);
    chk_val("timeout_still_sticky", timeout_err, 1'b1);

    // Reset after two result handshakes.
    hs0 = hs_cnt;
    feed(id_a, id_b, 0);
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), id_a[k*DW +: DW]});
    bus.done        = 1'b1;
    bus.result_flat = id_a;
    @(posedge clk);
    #1;
    bus.done        = 1'b0;
    bus.result_flat = '0;
    repeat (2) begin @(posedge clk); #1; end
    rst        = 1'b1;
    hold_ready = 1'b0;
    chk_val("pre_reset_handshakes", hs_cnt - hs0, 2);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_reset_state("mid_drain_reset");
    @(posedge clk);
    #1;
    rst        = 1'b0;
    hold_ready = 1'b1;
    exp_q.delete();
    run_job(id_a, id_b, mat_mul(id_a, id_b), 0, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_matrix_streamer.md
# systolic_matrix_streamer

Host-side sequencer for `systolic_array_top`. It accepts matrix A and matrix B as element streams and packs them into the array's flat operand buses. It then issues a single-cycle `start`, waits for `done`, captures `result_flat`, and serializes the result matrix onto an output stream with valid/ready handshake. It replaces bench-driven operand loading and result reading, and is the data path between the stream fabric and the array.

## Interface
- `ARRAY_SIZE`, 2: N. Matrices are N×N.
- `DATA_WIDTH`, 16: A and result element width, S5.10.
- `WEIGHT_WIDTH`, 8: B element width, S1.6.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent in WAIT before abort.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_a_valid` in 1; `s_a_ready` out 1; `s_a_data` in DATA_WIDTH: A elements, row-major.
- `s_b_valid` in 1; `s_b_ready` out 1; `s_b_data` in WEIGHT_WIDTH: B elements, row-major.
- `matrix_a_flat` out DATA_WIDTH·N²: to the array.
- `matrix_b_flat` out WEIGHT_WIDTH·N²: to the array.
- `start` out 1: one-cycle pulse to the array.
- `done` in 1; `result_valid` in 1; `result_flat` in DATA_WIDTH·N²: from the array.
- `m_valid` out 1; `m_ready` in 1; `m_data` out DATA_WIDTH; `m_last` out 1: result stream, row-major.
- `busy` out 1: high in every state other than LOAD.
- `timeout_err` out 1: sticky. Cleared only by `rst`.

## Operation
- States: LOAD → START → WAIT → DRAIN → LOAD. On WAIT timeout the FSM goes WAIT → LOAD.
- LOAD:
  - `s_a_ready` = (a_cnt < N²). `s_b_ready` = (b_cnt < N²).
  - On an A handshake, element k = a_cnt is written to `matrix_a_flat[k*DATA_WIDTH +: DATA_WIDTH]` and a_cnt increments. B is handled the same way into `matrix_b_flat`.
  - k = i·N + j is the index of element [i][j].
  - The two streams are independent. Either may complete first. Both may handshake in the same cycle.
  - When a_cnt = b_cnt = N² the FSM goes to START.
- START: `start` = 1 for exactly this cycle. Next state is WAIT. `done` is ignored in this cycle.
- WAIT:
  - A watchdog counter increments every cycle.
  - When `done` = 1, `result_flat` is captured into an internal register. `result_valid` is not required. The FSM goes to DRAIN.
  - If the watchdog reaches TIMEOUT_CYCLES−1 without `done`, `timeout_err` is set and the FSM returns to LOAD with counters cleared.
  - If `done` and the timeout occur in the same cycle, `done` wins.
- DRAIN:
  - `m_valid` = 1. `m_data` = captured element r_cnt. `m_last` = (r_cnt = N²−1).
  - On `m_valid & m_ready`, r_cnt increments.
  - The handshake on the last element moves the FSM to LOAD and clears a_cnt, b_cnt and r_cnt.
  - `m_data` and `m_last` hold stable while `m_ready` = 0.
- `matrix_*_flat` hold their values from the LOAD fill through START, WAIT and DRAIN. During the next LOAD they are overwritten element by element.
- `done` outside WAIT is ignored. `s_*_ready` are 0 outside LOAD.

## Timing
- Reset values:
  - FSM = LOAD; all counters = 0.
  - `matrix_a_flat` = `matrix_b_flat` = 0; captured result = 0.
  - `start` = `m_valid` = `m_last` = `busy` = `timeout_err` = 0.
  - `m_data` = 0.
  - `s_a_ready` = `s_b_ready` = 1 from the first cycle after reset deasserts.
- Ready and valid outputs are decoded from registered state. They have no combinational path from `s_*_valid` or `m_ready`.
- Last operand handshake in cycle t: `start` is high in t+1, WAIT begins at t+2.
- `done` sampled high in cycle d: `m_valid` is high in d+1 with element 0.
- Drain throughput is one element per cycle when `m_ready` is held high. Minimum drain length is N² cycles.
- Last result handshake in cycle e: `s_a_ready` and `s_b_ready` are high in e+1.
- `rst` asserted in any state, including mid-DRAIN or mid-WAIT, returns everything to reset values on the next edge. No partial output is resumed.

## Test plan
- **Identity 2×2.**
  - Stimulus: A = {0x0400, 0, 0, 0x0400}, B = {0x40, 0, 0, 0x40}, with real `systolic_array_top` attached.
  - Required: `matrix_a_flat` = 0x0400_0000_0000_0400 and `matrix_b_flat` = 0x4000_0040 at the `start` pulse.
  - Required: exactly one `start` pulse.
  - Required: `m_data` sequence 0x0400, 0x0000, 0x0000, 0x0400, with `m_last` only on the 4th element.
- **Order independence.**
  - Stimulus: stream all 4 B elements, then 4 A elements with gaps.
  - Required: identical flats; `start` exactly one cycle after the last A handshake.
- **Backpressure.**
  - Stimulus: result {0x0C00, 0x0800, 0xFC00, 0x0400}; `m_ready` toggles 1,0,0,1,…
  - Required: each value is held while `m_ready` = 0. No drop and no duplicate. Exactly 4 handshakes.
- **Timeout.**
  - Stimulus: stub array that never raises `done`; TIMEOUT_CYCLES = 16.
  - Required: `timeout_err` rises 16 cycles after WAIT entry; `s_a_ready` is high the next cycle; `m_valid` is never asserted.
- **Reset mid-drain.**
  - Stimulus: assert `rst` after 2 result handshakes.
  - Required: next cycle `m_valid` = 0, flats = 0, `busy` = 0.
  - Required: a new identity run then produces a correct full 4-element stream.
- **Spurious `done`.**
  - Stimulus: pulse `done` during LOAD and during the START cycle.
  - Required: no state change and no capture. The real `done` in WAIT is captured normally.
